// File: rtl/swap_arbiter_if.sv
// swap_arbiter_if
//   Request/sequence bus between the two swap requesters and swap_arbiter.
//
//   Handshake semantics: wN is a one-cycle strobe with no ready; aN/bN are
//   sampled on the same edge. The strobe is taken only when requester N has
//   no pending request, otherwise it is silently dropped. Completion is
//   reported by a one-cycle doneN pulse, with err alongside it when the
//   request was rejected. rout/rin are one-hot drive/load enables for the
//   register bank, busy is high whenever the sequencer is not IDLE, and
//   dbg_state exposes the sequencer FSM state.
//
//   Modports:
//     slave  : the arbiter (consumes strobes, produces enables and status)
//     master : the requester side / bench
interface swap_arbiter_if #(
    parameter int NREG = 6,
    parameter int AW   = 3
);
    logic            w0;
    logic [AW-1:0]   a0;
    logic [AW-1:0]   b0;
    logic            w1;
    logic [AW-1:0]   a1;
    logic [AW-1:0]   b1;
    logic [NREG-1:0] rout;
    logic [NREG-1:0] rin;
    logic            done0;
    logic            done1;
    logic            err;
    logic            busy;
    logic [2:0]      dbg_state;

    modport slave (
        input  w0, a0, b0, w1, a1, b1,
        output rout, rin, done0, done1, err, busy, dbg_state
    );

    modport master (
        output w0, a0, b0, w1, a1, b1,
        input  rout, rin, done0, done1, err, busy, dbg_state
    );
endinterface

// File: rtl/swap_arbiter.sv
// swap_arbiter
//   Queues one swap request per requester, grants them round-robin and
//   sequences each legal swap through the temp register X as three bus
//   transfers: X<-A, A<-B, B<-X. Carries no bus data itself.
//
//   Ports:
//     ck   : clock, rising edge
//     rst  : asynchronous, active-high reset
//     bus  : swap_arbiter_if.slave (strobes/indices in; rout, rin,
//            done0, done1, err, busy, dbg_state out)
module swap_arbiter #(
    parameter int NREG = 6,
    parameter int AW   = 3,
    parameter int X    = 2
) (
    input  logic           ck,
    input  logic           rst,
    swap_arbiter_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_T1   = 3'd1,
        S_T2   = 3'd2,
        S_T3   = 3'd3,
        S_DONE = 3'd4
    } state_t;

    localparam logic [AW-1:0] X_IDX    = AW'(X);
    localparam logic [AW:0]   NREG_LIM = (AW+1)'(NREG);

    function automatic logic is_legal(input logic [AW-1:0] a, input logic [AW-1:0] b);
        return (a != b) && (a != X_IDX) && (b != X_IDX) &&
               ({1'b0, a} < NREG_LIM) && ({1'b0, b} < NREG_LIM);
    endfunction

    function automatic logic [NREG-1:0] onehot(input logic [AW-1:0] i);
        return {{(NREG-1){1'b0}}, 1'b1} << i;
    endfunction

    state_t          state_q, state_d;
    logic            pend0_q, pend0_d, pend1_q, pend1_d;
    logic [AW-1:0]   pa0_q, pa0_d, pb0_q, pb0_d;
    logic [AW-1:0]   pa1_q, pa1_d, pb1_q, pb1_d;
    logic [AW-1:0]   cur_a_q, cur_a_d, cur_b_q, cur_b_d;
    logic            cur_id_q, cur_id_d;
    logic            cur_ill_q, cur_ill_d;
    logic            last_q, last_d;
    logic [NREG-1:0] rout_q, rout_d, rin_q, rin_d;
    logic            done0_q, done0_d, done1_q, done1_d;
    logic            err_q, err_d, busy_q, busy_d;
    logic            grant0, grant1;

    always_comb begin
        state_d   = state_q;
        pend0_d   = pend0_q;
        pend1_d   = pend1_q;
        pa0_d     = pa0_q;
        pb0_d     = pb0_q;
        pa1_d     = pa1_q;
        pb1_d     = pb1_q;
        cur_a_d   = cur_a_q;
        cur_b_d   = cur_b_q;
        cur_id_d  = cur_id_q;
        cur_ill_d = cur_ill_q;
        last_d    = last_q;
        rout_d    = '0;
        rin_d     = '0;
        done0_d   = 1'b0;
        done1_d   = 1'b0;
        err_d     = 1'b0;

        // With both pending, the requester that was not granted last wins.
        grant0 = (state_q == S_IDLE) && pend0_q && (!pend1_q || last_q);
        grant1 = (state_q == S_IDLE) && pend1_q && (!pend0_q || !last_q);

        case (state_q)
            S_IDLE: begin
                if (grant0 || grant1) begin
                    cur_id_d  = grant1;
                    cur_a_d   = grant1 ? pa1_q : pa0_q;
                    cur_b_d   = grant1 ? pb1_q : pb0_q;
                    cur_ill_d = !is_legal(cur_a_d, cur_b_d);
                    last_d    = grant1;
                    state_d   = cur_ill_d ? S_DONE : S_T1;
                end
            end
            S_T1:    state_d = S_T2;
            S_T2:    state_d = S_T3;
            S_T3:    state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // A slot is freed on its grant edge, so a strobe during its own
        // execution is accepted; a strobe on the grant edge itself is not.
        if (grant0) begin
            pend0_d = 1'b0;
        end else if (bus.w0 && !pend0_q) begin
            pend0_d = 1'b1;
            pa0_d   = bus.a0;
            pb0_d   = bus.b0;
        end
        if (grant1) begin
            pend1_d = 1'b0;
        end else if (bus.w1 && !pend1_q) begin
            pend1_d = 1'b1;
            pa1_d   = bus.a1;
            pb1_d   = bus.b1;
        end

        // Outputs are decoded from the next state so they are registered
        // yet line up with the state they belong to.
        case (state_d)
            S_T1: begin
                rout_d = onehot(cur_a_d);
                rin_d  = onehot(X_IDX);
            end
            S_T2: begin
                rout_d = onehot(cur_b_d);
                rin_d  = onehot(cur_a_d);
            end
            S_T3: begin
                rout_d = onehot(X_IDX);
                rin_d  = onehot(cur_b_d);
            end
            S_DONE: begin
                done0_d = !cur_id_d;
                done1_d = cur_id_d;
                err_d   = cur_ill_d;
            end
            default: ;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            pend0_q   <= 1'b0;
            pend1_q   <= 1'b0;
            pa0_q     <= '0;
            pb0_q     <= '0;
            pa1_q     <= '0;
            pb1_q     <= '0;
            cur_a_q   <= '0;
            cur_b_q   <= '0;
            cur_id_q  <= 1'b0;
            cur_ill_q <= 1'b0;
            last_q    <= 1'b1;
            rout_q    <= '0;
            rin_q     <= '0;
            done0_q   <= 1'b0;
            done1_q   <= 1'b0;
            err_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pend0_q   <= pend0_d;
            pend1_q   <= pend1_d;
            pa0_q     <= pa0_d;
            pb0_q     <= pb0_d;
            pa1_q     <= pa1_d;
            pb1_q     <= pb1_d;
            cur_a_q   <= cur_a_d;
            cur_b_q   <= cur_b_d;
            cur_id_q  <= cur_id_d;
            cur_ill_q <= cur_ill_d;
            last_q    <= last_d;
            rout_q    <= rout_d;
            rin_q     <= rin_d;
            done0_q   <= done0_d;
            done1_q   <= done1_d;
            err_q     <= err_d;
            busy_q    <= busy_d;
        end
    end

    assign bus.rout      = rout_q;
    assign bus.rin       = rin_q;
    assign bus.done0     = done0_q;
    assign bus.done1     = done1_q;
    assign bus.err       = err_q;
    assign bus.busy      = busy_q;
    assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_swap_arbiter.sv
// tb_swap_arbiter
//   Directed bench for swap_arbiter. Expected bus events (cycle stamp plus
//   done/err/rout/rin) are queued when a strobe is issued; a monitor pops
//   and compares whenever the DUT shows activity, and checks the one-hot
//   invariants every cycle. A small register bank model follows rout/rin.
module tb_swap_arbiter;
    localparam int NREG = 6;
    localparam int AW   = 3;
    localparam int X    = 2;
    localparam int W    = 31;

    logic ck  = 1'b0;
    logic rst = 1'b1;
    always #5 ck = ~ck;

    swap_arbiter_if #(.NREG(NREG), .AW(AW)) bus_if ();

    swap_arbiter #(.NREG(NREG), .AW(AW), .X(X)) dut (
        .ck  (ck),
        .rst (rst),
        .bus (bus_if)
    );

    logic [W-1:0] exp_q[$];
    int cyc = 0;
    int mon_checks = 0, mon_errors = 0;
    int drv_checks = 0, drv_errors = 0;

    always @(posedge ck) cyc <= cyc + 1;

    // Behavioural register bank on the shared bus.
    logic [7:0] bank[NREG];
    logic [7:0] bank_bus;
    always_comb begin
        bank_bus = '0;
        for (int i = 0; i < NREG; i++)
            if (bus_if.rout[i]) bank_bus = bank_bus | bank[i];
    end
    always @(posedge ck or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) bank[i] <= 8'(10 + i);
            bank[3] <= 8'd5;
            bank[4] <= 8'd9;
        end else begin
            for (int i = 0; i < NREG; i++)
                if (bus_if.rin[i]) bank[i] <= bank_bus;
        end
    end

    // Monitor: pops an expectation for every cycle with bus or done activity.
    logic [14:0]  mon_ev;
    logic [W-1:0] mon_got, mon_exp;
    always @(negedge ck) begin
        if (!rst) begin
            mon_checks++;
            if (!($countones(bus_if.rout) <= 1 && $countones(bus_if.rin) <= 1 &&
                  (bus_if.rout & bus_if.rin) == '0 && !(bus_if.done0 && bus_if.done1) &&
                  (!bus_if.err || bus_if.done0 || bus_if.done1))) begin
                mon_errors++;
                $display("FAIL invariant at cyc %0d: rout=%b rin=%b done0=%b done1=%b err=%b",
                         cyc, bus_if.rout, bus_if.rin, bus_if.done0, bus_if.done1, bus_if.err);
            end
            mon_ev = {bus_if.done0, bus_if.done1, bus_if.err, bus_if.rout, bus_if.rin};
            if (mon_ev != '0) begin
                mon_checks++;
                mon_got = {16'(cyc), mon_ev};
                if (exp_q.size() == 0) begin
                    mon_errors++;
                    $display("FAIL unexpected_event: got %h, expected nothing", mon_got);
                end else begin
                    mon_exp = exp_q.pop_front();
                    if (mon_got !== mon_exp) begin
                        mon_errors++;
                        $display("FAIL event: got cyc=%0d ev=%b, expected cyc=%0d ev=%b",
                                 mon_got[30:15], mon_got[14:0], mon_exp[30:15], mon_exp[14:0]);
                    end
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        drv_checks++;
        if (got !== exp) begin
            drv_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    function automatic logic [5:0] oh(input int i);
        logic [5:0] one;
        one = 6'd1;
        return one << i;
    endfunction

    function automatic void push_ev(input int t, input logic d0, input logic d1, input logic er,
                                    input logic [5:0] ro, input logic [5:0] ri);
        exp_q.push_back({16'(t), d0, d1, er, ro, ri});
    endfunction

    // Legal swap: T1 at t1, T2, T3, DONE in the following cycles.
    function automatic void push_swap(input int id, input int a, input int b, input int t1);
        push_ev(t1,     1'b0, 1'b0, 1'b0, oh(a), oh(X));
        push_ev(t1 + 1, 1'b0, 1'b0, 1'b0, oh(b), oh(a));
        push_ev(t1 + 2, 1'b0, 1'b0, 1'b0, oh(X), oh(b));
        push_ev(t1 + 3, id == 0, id == 1, 1'b0, 6'd0, 6'd0);
    endfunction

    // Called at a negedge; returns the cycle stamp of the sampling edge.
    task automatic strobe(input int id, input int a, input int b, output int e);
        if (id == 0) begin
            bus_if.w0 = 1'b1; bus_if.a0 = AW'(a); bus_if.b0 = AW'(b);
        end else begin
            bus_if.w1 = 1'b1; bus_if.a1 = AW'(a); bus_if.b1 = AW'(b);
        end
        @(negedge ck);
        bus_if.w0 = 1'b0;
        bus_if.w1 = 1'b0;
        e = cyc;
    endtask

    task automatic strobe_pair(input int a0, input int b0, input int a1, input int b1, output int e);
        bus_if.w0 = 1'b1; bus_if.a0 = AW'(a0); bus_if.b0 = AW'(b0);
        bus_if.w1 = 1'b1; bus_if.a1 = AW'(a1); bus_if.b1 = AW'(b1);
        @(negedge ck);
        bus_if.w0 = 1'b0;
        bus_if.w1 = 1'b0;
        e = cyc;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((exp_q.size() != 0 || bus_if.busy) && n < 60) begin
            @(negedge ck);
            n++;
        end
        check(name, 32'(exp_q.size()), 32'd0);
        check({name, "_busy"}, 32'(bus_if.busy), 32'd0);
        repeat (2) @(negedge ck);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge ck);
        rst = 1'b0;
        @(negedge ck);
    endtask

    int e, e2, e3;
    int ill_a[3] = '{3, 2, 6};
    int ill_b[3] = '{3, 4, 1};

    initial begin
        bus_if.w0 = 1'b0; bus_if.a0 = '0; bus_if.b0 = '0;
        bus_if.w1 = 1'b0; bus_if.a1 = '0; bus_if.b1 = '0;
        repeat (3) @(negedge ck);
        rst = 1'b0;
        @(negedge ck);

        // Reset state
        check("reset_rout",  32'(bus_if.rout),  32'd0);
        check("reset_rin",   32'(bus_if.rin),   32'd0);
        check("reset_done0", 32'(bus_if.done0), 32'd0);
        check("reset_done1", 32'(bus_if.done1), 32'd0);
        check("reset_err",   32'(bus_if.err),   32'd0);
        check("reset_busy",  32'(bus_if.busy),  32'd0);
        check("reset_state", 32'(bus_if.dbg_state), 32'd0);

        // Single swap of R3/R4 through X=R2
        strobe(0, 3, 4, e);
        push_swap(0, 3, 4, e + 1);
        @(negedge ck);
        check("single_busy_t1", 32'(bus_if.busy), 32'd1);
        drain("single");
        check("bank_r3", 32'(bank[3]), 32'd9);
        check("bank_r4", 32'(bank[4]), 32'd5);

        // Simultaneous after reset: requester 0 first, one IDLE cycle between
        do_reset();
        strobe_pair(3, 4, 4, 5, e);
        push_swap(0, 3, 4, e + 1);
        push_swap(1, 4, 5, e + 6);
        drain("pair_first");

        // Requester 0 alone leaves last=0, so requester 1 wins the next pair
        strobe(0, 5, 0, e);
        push_swap(0, 5, 0, e + 1);
        drain("single_5_0");
        strobe_pair(3, 4, 4, 5, e);
        push_swap(1, 4, 5, e + 1);
        push_swap(0, 3, 4, e + 6);
        drain("pair_second");

        // Illegal requests: a==b, a==X, a>=NREG
        for (int k = 0; k < 3; k++) begin
            strobe(1, ill_a[k], ill_b[k], e);
            push_ev(e + 1, 1'b0, 1'b1, 1'b1, 6'd0, 6'd0);
            drain("illegal");
        end

        // Queueing: re-request during T2, third strobe while pending is dropped
        strobe(0, 3, 4, e);
        push_swap(0, 3, 4, e + 1);
        push_swap(0, 3, 4, e + 6);
        repeat (2) @(negedge ck);
        check("queue_in_t2", 32'(bus_if.dbg_state), 32'd2);
        strobe(0, 3, 4, e2);
        strobe(0, 5, 0, e3);
        drain("queue");

        // Reset in the middle of T2
        strobe(0, 3, 4, e);
        push_ev(e + 1, 1'b0, 1'b0, 1'b0, oh(3), oh(X));
        push_ev(e + 2, 1'b0, 1'b0, 1'b0, oh(4), oh(3));
        repeat (2) @(negedge ck);
        #2 rst = 1'b1;
        #1;
        check("midrst_rout",  32'(bus_if.rout),  32'd0);
        check("midrst_rin",   32'(bus_if.rin),   32'd0);
        check("midrst_busy",  32'(bus_if.busy),  32'd0);
        check("midrst_state", 32'(bus_if.dbg_state), 32'd0);
        @(negedge ck);
        rst = 1'b0;
        check("midrst_queue", 32'(exp_q.size()), 32'd0);
        repeat (6) @(negedge ck);
        strobe(0, 1, 5, e);
        push_swap(0, 1, 5, e + 1);
        drain("after_reset");

        repeat (3) @(negedge ck);
        $display("Simulation finished: %0d checks, %0d errors",
                 mon_checks + drv_checks, mon_errors + drv_errors);
        $finish;
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end
endmodule
